qlearn_step_ctrl: RTL and testbench

Sequencer for one Q-learning iteration of the COC agent. It captures the observed network state, strobes the reward comparator, issues the Q-table read and write-back requests, and hands the chosen action to the antenna-tilt stage. It counts steps per episode and episodes per run, and raises done at run end. It sits between the network-state interface and the reward, Q-table and action datapath.

---
 rtl/qlearn_step_ctrl_if.sv | 26 ++
 rtl/qlearn_step_ctrl.sv | 155 +++++++++++++++
 tb/tb_qlearn_step_ctrl.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/qlearn_step_ctrl_if.sv
// Handshake bundle between the Q-learning step sequencer and its datapath:
// network-state input, reward comparator, Q-table request pair and action hand-off.
interface qlearn_step_ctrl_if;
  logic        s_valid;
  logic [2:0]  s_in;
  logic        rc_en;
  logic [2:0]  rc_state;
  logic [13:0] rc_reward;
  logic        q_rd_req;
  logic        q_rd_ack;
  logic        q_wr_req;
  logic        q_wr_ack;
  logic [13:0] reward_q;
  logic        act_valid;
  logic        act_ready;

  modport master (
    input  s_valid, s_in, rc_reward, q_rd_ack, q_wr_ack, act_ready,
    output rc_en, rc_state, q_rd_req, q_wr_req, reward_q, act_valid
  );

  modport slave (
    output s_valid, s_in, rc_reward, q_rd_ack, q_wr_ack, act_ready,
    input  rc_en, rc_state, q_rd_req, q_wr_req, reward_q, act_valid
  );
endinterface

// File: rtl/qlearn_step_ctrl.sv
// Sequencer for one Q-learning iteration: observe, reward, Q read/write, act.
// Optional macro WATCHDOG_EN bounds every ack wait to WD_LIMIT cycles and sets sticky wd_err.
module qlearn_step_ctrl #(
  parameter int STEPS_PER_EP = 16,
  parameter int NUM_EP       = 8,
  parameter int CNT_W        = 8,
  parameter int WD_LIMIT     = 255
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  start,
  qlearn_step_ctrl_if.master    bus,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_W-1:0]      step_cnt,
  output logic [CNT_W-1:0]      ep_cnt,
  output logic                  wd_err
);

  typedef enum logic [2:0] {
    IDLE, OBSERVE, REWARD, LATCH, QREAD, QWRITE, ACT, DONE
  } state_t;

  localparam logic [CNT_W-1:0] STEPS_C = CNT_W'(STEPS_PER_EP);
  localparam logic [CNT_W-1:0] NUM_C   = CNT_W'(NUM_EP);

  state_t            state, state_next;
  logic [CNT_W-1:0]  step_next, ep_next, step_inc, ep_inc;
  logic [2:0]        rc_state_r, rc_state_next;
  logic [13:0]       reward_r, reward_next;
  logic              handshake;

`ifdef WATCHDOG_EN
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(WD_LIMIT - 1);
  logic [CNT_W-1:0]  wd_cnt, wd_cnt_next;
  logic              wd_err_next;
`endif

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state      <= IDLE;
      step_cnt   <= '0;
      ep_cnt     <= '0;
      rc_state_r <= '0;
      reward_r   <= '0;
    end else begin
      state      <= state_next;
      step_cnt   <= step_next;
      ep_cnt     <= ep_next;
      rc_state_r <= rc_state_next;
      reward_r   <= reward_next;
    end
  end

  always_comb begin
    state_next    = state;
    step_next     = step_cnt;
    ep_next       = ep_cnt;
    rc_state_next = rc_state_r;
    reward_next   = reward_r;
    step_inc      = step_cnt + CNT_W'(1);
    ep_inc        = ep_cnt + CNT_W'(1);
    handshake     = 1'b0;

    case (state)
      IDLE: begin
        step_next = '0;
        ep_next   = '0;
        if (start) state_next = OBSERVE;
      end
      OBSERVE: begin
        if (bus.s_valid) begin
          rc_state_next = bus.s_in;
          state_next    = REWARD;
        end
      end
      REWARD: state_next = LATCH;
      LATCH: begin
        reward_next = bus.rc_reward;
        state_next  = QREAD;
      end
      QREAD: begin
        if (bus.q_rd_ack) begin
          handshake  = 1'b1;
          state_next = QWRITE;
        end
      end
      QWRITE: begin
        if (bus.q_wr_ack) begin
          handshake  = 1'b1;
          state_next = ACT;
        end
      end
      ACT: begin
        if (bus.act_ready) begin
          handshake = 1'b1;
          // Episode roll-over: the completed step closes the episode.
          if (step_inc == STEPS_C) begin
            step_next  = '0;
            ep_next    = ep_inc;
            state_next = (ep_inc == NUM_C) ? DONE : OBSERVE;
          end else begin
            step_next  = step_inc;
            state_next = OBSERVE;
          end
        end
      end
      DONE: begin
        if (!start) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

`ifdef WATCHDOG_EN
    wd_cnt_next = wd_cnt;
    wd_err_next = wd_err;
    if ((state == QREAD || state == QWRITE || state == ACT) && !handshake) begin
      if (wd_cnt == WD_LAST) begin
        wd_err_next = 1'b1;
        state_next  = DONE;
      end else begin
        wd_cnt_next = wd_cnt + CNT_W'(1);
      end
    end
    // Every state change is an entry into a fresh wait (or leaves the waits).
    if (state_next != state) wd_cnt_next = '0;
`endif
  end

`ifdef WATCHDOG_EN
  always_ff @(posedge CLK) begin
    if (!RST) begin
      wd_cnt <= '0;
      wd_err <= 1'b0;
    end else begin
      wd_cnt <= wd_cnt_next;
      wd_err <= wd_err_next;
    end
  end
`else
  logic unused_wd_limit;
  assign unused_wd_limit = |WD_LIMIT;
  assign wd_err          = 1'b0;
`endif

  assign bus.rc_en     = (state == REWARD);
  assign bus.rc_state  = rc_state_r;
  assign bus.q_rd_req  = (state == QREAD);
  assign bus.q_wr_req  = (state == QWRITE);
  assign bus.reward_q  = reward_r;
  assign bus.act_valid = (state == ACT);
  assign busy          = (state != IDLE) && (state != DONE);
  assign done          = (state == DONE);

endmodule

// File: tb/tb_qlearn_step_ctrl.sv
// Directed self-checking bench for qlearn_step_ctrl (2 steps x 2 episodes, WD_LIMIT 10).
module tb_qlearn_step_ctrl;
  localparam int STEPS = 2;
  localparam int NEP   = 2;
  localparam int CW    = 8;
  localparam int WDL   = 10;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          start = 1'b0;
  logic          busy, done, wd_err;
  logic [CW-1:0] step_cnt, ep_cnt;

  int testsRun    = 0;
  int testsFailed = 0;
  int rcEnCount   = 0;
  int stepExp     = 0;
  int epExp       = 0;
  int rcBase      = 0;

  qlearn_step_ctrl_if bus();

  qlearn_step_ctrl #(
    .STEPS_PER_EP(STEPS),
    .NUM_EP(NEP),
    .CNT_W(CW),
    .WD_LIMIT(WDL)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .start(start),
    .bus(bus),
    .busy(busy),
    .done(done),
    .step_cnt(step_cnt),
    .ep_cnt(ep_cnt),
    .wd_err(wd_err)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) if (bus.rc_en) rcEnCount++;

  initial begin
    #500000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] hsVec();
    return 32'({bus.rc_en, bus.q_rd_req, bus.q_wr_req, bus.act_valid});
  endfunction

  // One step from OBSERVE. Returns early while in the first QREAD cycle when abortInQread is set.
  task automatic applyStimulus(input logic [2:0] s, input logic [13:0] rw, input int rdDelay,
                               input int wrDelay, input int actDelay, input bit spurious,
                               input bit abortInQread);
    int wrHigh;
    int actHigh;
    checkOutput("busy_observe", 32'({busy, done}), 32'b10);
    bus.s_valid   = 1'b1;
    bus.s_in      = s;
    bus.rc_reward = 14'h1555;
    tick;
    bus.s_valid = 1'b0;
    bus.s_in    = 3'd0;
    checkOutput("rc_en_strobe", 32'({bus.rc_en, bus.rc_state}), 32'({1'b1, s}));
    tick;
    checkOutput("rc_en_one_cycle", 32'(bus.rc_en), 0);
    bus.rc_reward = rw;
    tick;
    bus.rc_reward = 14'h1555;
    checkOutput("reward_latch", 32'(bus.reward_q), 32'(rw));
    checkOutput("qread_enter", hsVec(), 32'b0100);
    if (abortInQread) return;
    for (int c = 1; c <= rdDelay; c++) begin
      bus.s_valid  = spurious;
      bus.q_wr_ack = spurious;
      bus.s_in     = 3'd7;
      tick;
      checkOutput("qread_hold", hsVec(), 32'b0100);
      checkOutput("qread_step_hold", 32'(step_cnt), 32'(stepExp));
    end
    bus.s_valid  = 1'b0;
    bus.s_in     = 3'd0;
    bus.q_wr_ack = 1'b0;
    bus.q_rd_ack = 1'b1;
    tick;
    bus.q_rd_ack = 1'b0;
    checkOutput("qwrite_enter", hsVec(), 32'b0010);
    wrHigh = 0;
    for (int c = 1; c <= wrDelay + 1; c++) begin
      if (bus.q_wr_req) wrHigh++;
      bus.q_wr_ack = (c == wrDelay + 1);
      tick;
    end
    bus.q_wr_ack = 1'b0;
    checkOutput("q_wr_req_cycles", 32'(wrHigh), 32'(wrDelay + 1));
    checkOutput("act_enter", hsVec(), 32'b0001);
    checkOutput("reward_stable", 32'(bus.reward_q), 32'(rw));
    actHigh = 0;
    for (int c = 1; c <= actDelay + 1; c++) begin
      if (bus.act_valid) actHigh++;
      bus.act_ready = (c == actDelay + 1);
      tick;
    end
    bus.act_ready = 1'b0;
    stepExp++;
    if (stepExp == STEPS) begin
      stepExp = 0;
      epExp++;
    end
    checkOutput("act_valid_cycles", 32'(actHigh), 32'(actDelay + 1));
    checkOutput("act_valid_drop", 32'(bus.act_valid), 0);
    checkOutput("step_cnt", 32'(step_cnt), 32'(stepExp));
    checkOutput("ep_cnt", 32'(ep_cnt), 32'(epExp));
    checkOutput("done_flag", 32'(done), 32'(epExp == NEP));
  endtask

  initial begin
    bus.s_valid   = 1'b0;
    bus.s_in      = 3'd0;
    bus.rc_reward = 14'h0;
    bus.q_rd_ack  = 1'b0;
    bus.q_wr_ack  = 1'b0;
    bus.act_ready = 1'b0;
    tick;
    tick;
    checkOutput("reset_ctrl", 32'({busy, done, hsVec()[3:0], wd_err}), 0);
    checkOutput("reset_data", 32'({bus.rc_state, bus.reward_q}), 0);
    checkOutput("reset_counters", 32'({step_cnt, ep_cnt}), 0);
    RST = 1'b1;
    tick;
    checkOutput("idle_quiet", 32'({busy, done, hsVec()[3:0]}), 0);

    // Full run: 4 steps, two episodes
    start = 1'b1;
    tick;
    start  = 1'b0;
    rcBase = rcEnCount;
    applyStimulus(3'd1, 14'h0C00, 0, 0, 0, 1'b0, 1'b0);
    applyStimulus(3'd3, 14'h0123, 0, 5, 3, 1'b0, 1'b0);
    applyStimulus(3'd3, 14'h3F00, 2, 0, 0, 1'b1, 1'b0);
    start = 1'b1;
    applyStimulus(3'd2, 14'h2001, 0, 0, 0, 1'b0, 1'b0);
    checkOutput("rc_en_pulses", 32'(rcEnCount - rcBase), 4);
    checkOutput("run_done", 32'({busy, done}), 32'b01);
    for (int c = 0; c < 3; c++) begin
      tick;
      checkOutput("done_held_start", 32'({busy, done, ep_cnt}), 32'({1'b0, 1'b1, 8'd2}));
    end
    start = 1'b0;
    tick;
    checkOutput("back_to_idle", 32'({busy, done}), 0);
    tick;
    checkOutput("idle_clears", 32'({step_cnt, ep_cnt}), 0);

    // Reset while a Q-table read is pending
    stepExp = 0;
    epExp   = 0;
    start   = 1'b1;
    tick;
    start = 1'b0;
    applyStimulus(3'd5, 14'h0ABC, 0, 0, 0, 1'b0, 1'b0);
    applyStimulus(3'd6, 14'h0777, 0, 0, 0, 1'b0, 1'b1);
    checkOutput("pre_reset_step", 32'(step_cnt), 1);
    RST = 1'b0;
    tick;
    checkOutput("midrun_reset_ctrl", 32'({busy, done, hsVec()[3:0], wd_err}), 0);
    checkOutput("midrun_reset_data", 32'({bus.rc_state, bus.reward_q}), 0);
    checkOutput("midrun_reset_counters", 32'({step_cnt, ep_cnt}), 0);
    RST = 1'b1;
    tick;
    checkOutput("post_reset_idle", 32'({busy, done, hsVec()[3:0]}), 0);
    stepExp = 0;
    epExp   = 0;

`ifdef WATCHDOG_EN
    begin
      int rdHigh;
      start = 1'b1;
      tick;
      applyStimulus(3'd4, 14'h0042, 0, 0, 0, 1'b0, 1'b1);
      rdHigh = 0;
      for (int c = 0; c < 50 && bus.q_rd_req; c++) begin
        rdHigh++;
        tick;
      end
      checkOutput("wd_wait_cycles", 32'(rdHigh), 32'(WDL));
      checkOutput("wd_trip", 32'({done, wd_err, bus.q_rd_req, busy}), 32'b1100);
      tick;
      tick;
      checkOutput("wd_done_held", 32'({done, wd_err}), 32'b11);
      start = 1'b0;
      tick;
      checkOutput("wd_sticky", 32'({done, wd_err}), 32'b01);
      RST = 1'b0;
      tick;
      checkOutput("wd_reset", 32'(wd_err), 0);
      RST = 1'b1;
      tick;
    end
`else
    checkOutput("wd_err_tied", 32'(wd_err), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule
